// File: rtl/pulse_sweep_sequencer.sv
// Steps divider/duty through a programmed list of sweep points, each held for a fixed dwell.
// Outside a sweep both outputs stay at 0, which holds the downstream mask in reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | outputs zero; waiting for start with a non-zero point count
// S_DWELL | driving the current point; counter runs 0..D-1 per point
module pulse_sweep_sequencer #(
   parameter int W     = 32,
   parameter int STEPW = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             continuous,
   input  logic [W-1:0]     div_start,
   input  logic [W-1:0]     div_step,
   input  logic [W-1:0]     duty_start,
   input  logic [W-1:0]     duty_step,
   input  logic [STEPW-1:0] num_points,
   input  logic [W-1:0]     dwell,
   output logic [W-1:0]     divider,
   output logic [W-1:0]     duty,
   output logic [STEPW-1:0] point_idx,
   output logic             point_strobe,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {S_IDLE, S_DWELL} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     cnt, cnt_nxt;
   logic [W-1:0]     divider_nxt, duty_nxt;
   logic [STEPW-1:0] idx_nxt;
   logic             strobe_nxt, busy_nxt, done_nxt;

   logic [W-1:0]     div_start_q, div_step_q, duty_start_q, duty_step_q;
   logic [W-1:0]     cnt_last_q;
   logic [STEPW-1:0] idx_last_q;
   logic             cont_q;

   logic go, at_tc, last_pt, load_cfg;

   // Two guard bits keep both underflow and overflow visible before clamping to [1, 2^W-1].
   function automatic logic [W-1:0] step_clamp(input logic [W-1:0] v, input logic [W-1:0] s);
      logic [W+1:0] sum;
      sum = {2'b00, v} + {{2{s[W-1]}}, s};
      if (sum[W+1] || (sum == '0))
         step_clamp = {{(W-1){1'b0}}, 1'b1};
      else if (sum[W])
         step_clamp = '1;
      else
         step_clamp = sum[W-1:0];
   endfunction

   assign go       = start && !abort && (num_points != '0);
   assign load_cfg = (state == S_IDLE) && go;
   assign at_tc    = (cnt == cnt_last_q);
   assign last_pt  = (point_idx == idx_last_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         divider      <= '0;
         duty         <= '0;
         point_idx    <= '0;
         point_strobe <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         divider      <= divider_nxt;
         duty         <= duty_nxt;
         point_idx    <= idx_nxt;
         point_strobe <= strobe_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_start_q  <= '0;
         div_step_q   <= '0;
         duty_start_q <= '0;
         duty_step_q  <= '0;
         cnt_last_q   <= '0;
         idx_last_q   <= '0;
         cont_q       <= 1'b0;
      end else if (load_cfg) begin
         div_start_q  <= div_start;
         div_step_q   <= div_step;
         duty_start_q <= duty_start;
         duty_step_q  <= duty_step;
         cnt_last_q   <= (dwell == '0) ? '0 : dwell - W'(1);
         idx_last_q   <= num_points - STEPW'(1);
         cont_q       <= continuous;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (go) state_nxt = S_DWELL;
         S_DWELL: begin
            if (abort)
               state_nxt = S_IDLE;
            else if (at_tc && last_pt && !cont_q)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt     = '0;
      divider_nxt = '0;
      duty_nxt    = '0;
      idx_nxt     = '0;
      strobe_nxt  = 1'b0;
      done_nxt    = 1'b0;
      busy_nxt    = (state_nxt == S_DWELL);
      case (state)
         S_IDLE: begin
            if (go) begin
               divider_nxt = div_start;
               duty_nxt    = duty_start;
               strobe_nxt  = 1'b1;
            end
         end
         S_DWELL: begin
            if (abort) begin
               cnt_nxt = '0;
            end else if (!at_tc) begin
               cnt_nxt     = cnt + W'(1);
               divider_nxt = divider;
               duty_nxt    = duty;
               idx_nxt     = point_idx;
            end else if (!last_pt) begin
               divider_nxt = step_clamp(divider, div_step_q);
               duty_nxt    = step_clamp(duty, duty_step_q);
               idx_nxt     = point_idx + STEPW'(1);
               strobe_nxt  = 1'b1;
            end else if (cont_q) begin
               divider_nxt = div_start_q;
               duty_nxt    = duty_start_q;
               strobe_nxt  = 1'b1;
            end else begin
               done_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pulse_sweep_sequencer.sv
// Bench for pulse_sweep_sequencer: directed and random sweeps compared cycle by cycle
// against a point-list model built from start/step arithmetic with clamping.
module tb_pulse_sweep_sequencer;
   localparam int W     = 32;
   localparam int STEPW = 16;

   logic             clk = 1'b0;
   logic             reset, start, abort, continuous;
   logic [W-1:0]     div_start, div_step, duty_start, duty_step, dwell;
   logic [STEPW-1:0] num_points;
   logic [W-1:0]     divider, duty;
   logic [STEPW-1:0] point_idx;
   logic             point_strobe, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_sweep_sequencer #(.W(W), .STEPW(STEPW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
      .div_start(div_start), .div_step(div_step), .duty_start(duty_start), .duty_step(duty_step),
      .num_points(num_points), .dwell(dwell),
      .divider(divider), .duty(duty), .point_idx(point_idx),
      .point_strobe(point_strobe), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input longint e_div, input longint e_duty,
                          input int e_idx, input bit e_strb, input bit e_busy, input bit e_done);
      chk({tag, ".divider"}, divider, 32'(e_div));
      chk({tag, ".duty"},    duty,    32'(e_duty));
      chk({tag, ".idx"},     {16'b0, point_idx}, 32'(e_idx));
      chk({tag, ".strobe"},  {31'b0, point_strobe}, {31'b0, e_strb});
      chk({tag, ".busy"},    {31'b0, busy}, {31'b0, e_busy});
      chk({tag, ".done"},    {31'b0, done}, {31'b0, e_done});
   endtask

   // Next point value: signed step added to the unsigned value, clamped to [1, 2^32-1].
   function automatic longint next_val(input longint v, input logic [31:0] s);
      longint r;
      r = v + longint'($signed(s));
      if (r < 1) r = 1;
      else if (r > 64'd4294967295) r = 64'd4294967295;
      return r;
   endfunction

   task automatic idle_cycles(input string tag, input int n);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_out(tag, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Enter and leave just after a falling edge. abort_at < 0 means no abort (required >= 0 if cont).
   task automatic run_sweep(input string tag, input logic [31:0] ds, input logic [31:0] dst,
                            input logic [31:0] us, input logic [31:0] ust, input int n,
                            input logic [31:0] dw, input bit cont, input int abort_at,
                            input bit scramble);
      longint dp[$];
      longint up[$];
      int d, total, lim, p;
      bit ab;
      ab = 1'b0;
      dp.push_back(longint'(ds));
      up.push_back(longint'(us));
      for (int i = 1; i < n; i++) begin
         dp.push_back(next_val(dp[i-1], dst));
         up.push_back(next_val(up[i-1], ust));
      end
      d     = (dw == 0) ? 1 : int'(dw);
      total = n * d;
      lim   = cont ? abort_at + 1 : total + 1;
      div_start = ds; div_step = dst; duty_start = us; duty_step = ust;
      num_points = 16'(n); dwell = dw; continuous = cont;
      start = 1'b1; abort = 1'b0;
      for (int k = 0; k <= lim; k++) begin
         @(negedge clk);
         if (ab) begin
            chk_out({tag, ".abort"}, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            break;
         end
         if (!cont && k == total) begin
            chk_out({tag, ".done"}, 0, 0, 0, 1'b0, 1'b0, 1'b1);
            start = 1'b0;
            continue;
         end
         if (!cont && k == total + 1) begin
            chk_out({tag, ".after"}, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            break;
         end
         p = (k / d) % n;
         chk_out(tag, dp[p], up[p], p, (k % d) == 0, 1'b1, 1'b0);
         start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
         if (scramble) begin
            div_start = $urandom; div_step = $urandom;
            duty_start = $urandom; duty_step = $urandom;
            num_points = 16'($urandom_range(0, 7));
            dwell = $urandom_range(0, 7);
            continuous = 1'($urandom_range(0, 1));
         end
         if (k == abort_at) begin
            abort = 1'b1;
            ab = 1'b1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      int n, total, abort_at, sel;
      logic [31:0] ds, dst, us, ust, dw;
      bit cont;
      reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
      div_start = '0; div_step = '0; duty_start = '0; duty_step = '0;
      num_points = '0; dwell = '0;
      #12;
      chk_out("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      idle_cycles("idle", 2);

      run_sweep("t1", 32'd100, 32'd10, 32'd50, 32'd5, 3, 32'd4, 1'b0, -1, 1'b0);
      run_sweep("t2", 32'd20, 32'hFFFF_FFF1, 32'hFFFF_FFF0, 32'h20, 3, 32'd1, 1'b0, -1, 1'b0);
      run_sweep("t3", 32'd7, 32'd3, 32'd9, 32'd1, 2, 32'd3, 1'b1, 14, 1'b0);

      num_points = '0; start = 1'b1;
      @(negedge clk);
      chk_out("n0", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      run_sweep("t4", 32'd300, 32'hFFFF_FF9C, 32'd2, 32'd2, 2, 32'd0, 1'b0, -1, 1'b0);
      run_sweep("n1", 32'd5, 32'd1, 32'd6, 32'd1, 1, 32'd3, 1'b0, -1, 1'b0);
      run_sweep("n1c", 32'd5, 32'd1, 32'd6, 32'd1, 1, 32'd2, 1'b1, 5, 1'b0);
      run_sweep("ablast", 32'd40, 32'd2, 32'd30, 32'd1, 2, 32'd2, 1'b0, 3, 1'b0);

      div_start = 32'd77; div_step = 32'd1; duty_start = 32'd33; duty_step = 32'd1;
      num_points = 16'd4; dwell = 32'd5; continuous = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_out("rst_mid", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      idle_cycles("rst_after", 2);

      num_points = 16'd3; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk_out("start_abort", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      @(negedge clk);
      chk_out("abort_idle", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      abort = 1'b0;

      run_sweep("t6", 32'd1000, 32'd7, 32'd400, 32'hFFFF_FFFD, 3, 32'd3, 1'b0, -1, 1'b1);

      for (int r = 0; r < 12; r++) begin
         sel = $urandom_range(0, 2);
         if (sel == 0) begin
            ds = $urandom; dst = $urandom; us = $urandom; ust = $urandom;
         end else if (sel == 1) begin
            ds = $urandom_range(1, 50); dst = -$urandom_range(0, 30);
            us = $urandom_range(1, 50); ust = -$urandom_range(0, 30);
         end else begin
            ds = 32'hFFFF_FF00 + $urandom_range(0, 255); dst = $urandom_range(0, 200);
            us = 32'hFFFF_FF00 + $urandom_range(0, 255); ust = $urandom_range(0, 200);
         end
         n     = $urandom_range(1, 5);
         dw    = $urandom_range(0, 4);
         cont  = 1'($urandom_range(0, 1));
         total = n * ((dw == 0) ? 1 : int'(dw));
         if (cont) abort_at = $urandom_range(0, 2 * total + 2);
         else if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(0, total - 1);
         else abort_at = -1;
         run_sweep("rand", ds, dst, us, ust, n, dw, cont, abort_at, 1'b1);
         idle_cycles("rand_idle", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
